// File: rtl/tictactoe_game_ctrl.sv
// tictactoe_game_ctrl: 3x3 board owner that validates moves, alternates players and latches win/draw.
module tictactoe_game_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [3:0]  move_cell,
  output logic        move_ready,
  output logic        move_ack,
  output logic        move_err,
  output logic        turn,
  output logic [17:0] board,
  output logic [1:0]  winner,
  output logic        draw,
  output logic        game_over
);
  typedef enum logic [1:0] {PLAY, EVAL, OVER} state_t;
  localparam logic [71:0] win_lines = {9'h007, 9'h038, 9'h1c0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};
  state_t      state;
  logic [3:0]  move_count;
  logic [1:0]  mark;
  logic [1:0]  target;
  logic [31:0] board_ext;
  logic [8:0]  owned;
  logic        line_win;
  logic        legal;
  assign mark      = turn ? 2'b10 : 2'b01;
  assign board_ext = {14'd0, board};
  assign target    = board_ext[{move_cell, 1'b0} +: 2];
  assign legal     = (move_cell <= 4'd8) && (target == 2'b00);
  genvar i;
  generate
    for (i = 0; i < 9; i++) begin : g_own
      assign owned[i] = board[2*i +: 2] == mark;
    end
  endgenerate
  always_comb begin
    line_win = 1'b0;
    for (int l = 0; l < 8; l++)
      line_win = line_win | ((owned & win_lines[9*l +: 9]) == win_lines[9*l +: 9]);
  end
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state      <= PLAY;
      board      <= '0;
      turn       <= 1'b0;
      winner     <= 2'b00;
      draw       <= 1'b0;
      game_over  <= 1'b0;
      move_ack   <= 1'b0;
      move_err   <= 1'b0;
      move_count <= '0;
      move_ready <= 1'b1;
    end else begin
      move_ack <= 1'b0;
      move_err <= 1'b0;
      case (state)
        PLAY: if (move_valid) begin
          if (legal) begin
            for (int c = 0; c < 9; c++)
              if (move_cell == 4'(c)) board[2*c +: 2] <= mark;
            move_count <= move_count + 4'd1;
            move_ack   <= 1'b1;
            move_ready <= 1'b0;
            state      <= EVAL;
          end else
            move_err <= 1'b1;
        end
        EVAL: if (line_win) begin
          winner    <= mark;
          game_over <= 1'b1;
          state     <= OVER;
        end else if (move_count == 4'd9) begin
          draw      <= 1'b1;
          game_over <= 1'b1;
          state     <= OVER;
        end else begin
          turn       <= ~turn;
          move_ready <= 1'b1;
          state      <= PLAY;
        end
        OVER: move_err <= move_valid;
        default: state <= PLAY;
      endcase
    end
  end
endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// tb_tictactoe_game_ctrl: directed and random play checked against a cell-array game model.
module tb_tictactoe_game_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_game = 1'b0;
  logic        move_valid = 1'b0;
  logic [3:0]  move_cell = 4'd0;
  logic        move_ready, move_ack, move_err, turn, draw, game_over;
  logic [17:0] board;
  logic [1:0]  winner;
  int n_checks = 0;
  int n_pass = 0;
  int cells[9];
  int m_turn, m_win, m_draw, m_phase, m_ack, m_err;
  tictactoe_game_ctrl dut (
    .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
    .move_cell(move_cell), .move_ready(move_ready), .move_ack(move_ack),
    .move_err(move_err), .turn(turn), .board(board), .winner(winner),
    .draw(draw), .game_over(game_over)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic bit has_line(input int m);
    for (int k = 0; k < 3; k++) begin
      if (cells[3*k] == m && cells[3*k+1] == m && cells[3*k+2] == m) return 1'b1;
      if (cells[k] == m && cells[k+3] == m && cells[k+6] == m) return 1'b1;
    end
    return (cells[0] == m && cells[4] == m && cells[8] == m) ||
           (cells[2] == m && cells[4] == m && cells[6] == m);
  endfunction
  function automatic int filled();
    int n = 0;
    for (int k = 0; k < 9; k++) if (cells[k] != 0) n++;
    return n;
  endfunction
  function automatic logic [17:0] exp_board();
    logic [17:0] b = '0;
    for (int k = 0; k < 9; k++) b = b | (18'(cells[k]) << (2*k));
    return b;
  endfunction
  // phase: 0 accepting moves, 1 judging the last move, 2 game finished
  task automatic step(input logic r, input logic n, input logic v, input int c);
    rst = r; new_game = n; move_valid = v; move_cell = 4'(c);
    @(posedge clk);
    if (r || n) begin
      foreach (cells[k]) cells[k] = 0;
      m_turn = 0; m_win = 0; m_draw = 0; m_phase = 0; m_ack = 0; m_err = 0;
    end else begin
      m_ack = 0; m_err = 0;
      if (m_phase == 0 && v) begin
        if (c > 8 || cells[c] != 0) m_err = 1;
        else begin cells[c] = m_turn + 1; m_ack = 1; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (has_line(m_turn + 1)) begin m_win = m_turn + 1; m_phase = 2; end
        else if (filled() == 9) begin m_draw = 1; m_phase = 2; end
        else begin m_turn = 1 - m_turn; m_phase = 0; end
      end else if (m_phase == 2) m_err = v;
    end
    #1;
    check("board", 32'(board), 32'(exp_board()));
    check("turn", 32'(turn), m_turn);
    check("winner", 32'(winner), m_win);
    check("draw", 32'(draw), m_draw);
    check("game_over", 32'(game_over), 32'(m_win != 0 || m_draw != 0));
    check("move_ready", 32'(move_ready), 32'(m_phase == 0));
    check("move_ack", 32'(move_ack), m_ack);
    check("move_err", 32'(move_err), m_err);
  endtask
  task automatic play(input int c);
    step(0, 0, 1, c);
    step(0, 0, 0, 0);
  endtask
  initial begin
    int seq_win[5] = '{0, 3, 1, 4, 2};
    int seq_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    step(1, 0, 0, 0);
    step(1, 0, 1, 4);
    foreach (seq_win[k]) play(seq_win[k]);
    check("win_board", 32'(board), 32'h00295);
    check("win_winner", 32'(winner), 32'd1);
    check("win_turn", 32'(turn), 32'd0);
    check("win_ready", 32'(move_ready), 32'd0);
    step(0, 0, 1, 5);
    check("over_err", 32'(move_err), 32'd1);
    check("over_board", 32'(board), 32'h00295);
    step(0, 1, 0, 0);
    foreach (seq_draw[k]) play(seq_draw[k]);
    check("draw_board", 32'(board), 32'h16a59);
    check("draw_flag", 32'(draw), 32'd1);
    check("draw_winner", 32'(winner), 32'd0);
    step(0, 1, 0, 0);
    play(4);
    step(0, 0, 1, 4);
    check("occupied_err", 32'(move_err), 32'd1);
    check("occupied_turn", 32'(turn), 32'd1);
    step(0, 0, 1, 9);
    check("range_err", 32'(move_err), 32'd1);
    step(0, 0, 1, 0);
    check("retry_ack", 32'(move_ack), 32'd1);
    step(0, 0, 0, 0);
    step(0, 1, 1, 5);
    check("ng_prio_board", 32'(board), 32'd0);
    check("ng_prio_ack", 32'(move_ack), 32'd0);
    play(0); play(3); play(1); play(4);
    step(0, 0, 1, 2);
    step(0, 1, 0, 0);
    check("ng_eval_winner", 32'(winner), 32'd0);
    check("ng_eval_turn", 32'(turn), 32'd0);
    check("ng_eval_ready", 32'(move_ready), 32'd1);
    for (int k = 0; k < 14; k++) step(0, 0, 1, k / 2);
    step(0, 1, 0, 0);
    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 10)));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
